bsg_manycore_block_mem_channel_array: RTL and testbench
=======================================================

// Module: bsg_manycore_block_mem_channel_array
// PURPOSE
//  Parametrised row of independent block-memory channels on a pod edge; one channel per column.
//  - Each channel: buffered valid/ready request port, single-port SRAM model, 2-entry response queue.
//  - Each channel has a staged reset fan-out for downstream logic.
//  - Generalises the per-column block-mem row with:
//    - configurable depth and width;
//    - bounded outstanding requests with backpressure;
//    - out-of-range error reporting;
//    - optional atomic add.
// PARAMETERS
//  num_channels_p   4     number of independent channels (columns)
//  data_width_p     32    word width; mask width = data_width_p/8
//  addr_width_p     16    word-address width presented on the request port
//  els_p            1024  words per channel; lg_els = clog2(els_p); must be <= 2**addr_width_p
//  reset_depth_p    2     flop stages on each reset_n_o path (>=1)
// PORTS
//  clk_i       in   1                     single clock
//  reset_n_i   in   1                     asynchronous active-low reset
//  reset_n_o   out  C                     per-channel staged reset, active-low
//  v_i         in   C                     request valid
//  op_i        in   C x 2                 00 load, 01 store, 10 amoadd, 11 reserved
//  addr_i      in   C x addr_width_p      word address
//  data_i      in   C x data_width_p      store / add operand
//  mask_i      in   C x data_width_p/8    byte enables (store only)
//  ready_o     out  C                     request accepted when v_i & ready_o
//  v_o         out  C                     response valid (head of response queue)
//  data_o      out  C x data_width_p      load data / old value (amo) / 0 (store, error)
//  err_o       out  C                     response error flag
//  yumi_i      in   C                     response consumed; legal only when v_o
// BEHAVIOUR
//  Clocking and reset:
//  - Clock is clk_i only. Reset is reset_n_i: asynchronous assert, active low.
//  - Reset clears all state. SRAM contents are not cleared.
//  - Reset values: v_o=0, ready_o=0, err_o=0, data_o=0, reset_n_o=0.
//  - ready_o rises the 1st clock after reset_n_i deasserts.
//  - reset_n_o[c]: asserts asynchronously with reset_n_i; deasserts reset_depth_p clocks after it.
//  Per-channel FSM: IDLE -> (accept amoadd) AMO_WR -> IDLE.
//  - Load/store/error never leave IDLE.
//  Credits:
//  - cnt = requests in flight + responses queued, range 0..2.
//  - ready_o = (state==IDLE) & (cnt<2).
//  - Accept and yumi in the same cycle leave cnt unchanged.
//  Latency, measured from the accept edge T:
//  - load: SRAM read at T; response enqueued and v_o=1 at T+1 when the queue was empty.
//  - store: masked byte write at T; ack response (data_o=0, err_o=0) at T+1.
//  - amoadd: read at T; write old+data_i (mod 2**data_width_p, carry dropped) at T+1 in AMO_WR;
//    response = old value at T+2; ready_o=0 during AMO_WR.
//  - Read-after-write on back-to-back requests returns the new data; the SRAM is write-first.
//  Error responses (err_o=1, data_o=0, no SRAM access, latency 1):
//  - addr_i >= els_p;
//  - op_i==11.
//  Response queue:
//  - FIFO ordered.
//  - With the queue full and no yumi, cnt==2 and ready_o=0. No response is ever dropped.
//  - yumi_i without v_o is an assertion failure in simulation.
//  Channels:
//  - Channels are fully independent. There is no cross-channel ordering.
//  - Inputs and outputs of channel c are packed at index c.
//  Reset mid-operation:
//  - In-flight amo write is abandoned.
//  - The SRAM word may hold the old or the new value; both are legal.
// CONFIGURATION
//  BSG_BLOCK_MEM_CHANNEL_AMO_EN
//  - Defined: amoadd is implemented as above.
//  - Undefined: op 10 is handled like 11 (error response, latency 1, no write).
//    AMO_WR state and adder are not built; FSM is IDLE only.
// TESTING
//  1. Reset: hold reset_n_i=0 5 cycles, release.
//     -> outputs 0.
//     -> ready_o=1 at +1.
//     -> reset_n_o=1 exactly reset_depth_p(=2) cycles after release.
//  2. Ch0 store addr 5, data 0xDEADBEEF, mask 0xF; load addr 5 next cycle.
//     -> load v_o one cycle after its accept, data_o=0xDEADBEEF.
//     -> ch1..3 v_o stay 0.
//  3. Store 0x11223344 mask 0x5 over 0xFFFFFFFF; load.
//     -> 0xFF22FF44.
//  4. Address 1024 with els_p=1024.
//     -> err_o=1, data_o=0, latency 1.
//     -> reading word 0 afterwards is unchanged.
//  5. yumi_i=0; issue 3 loads back-to-back.
//     -> ready_o=0 after 2 accepts.
//     -> single yumi -> ready_o=1 next cycle.
//     -> responses in order.
//  6. AMO_EN: word=0xFFFFFFFF, amoadd 2.
//     -> response 0xFFFFFFFF at T+2, then load returns 0x00000001.
//     -> ready_o=0 at T+1.
//     -> without macro: err_o=1 at T+1, word unchanged.

Source files
------------

// File: rtl/bsg_manycore_block_mem_channel_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bsg_manycore_block_mem_channel_array                             |
// | Purpose : Row of independent block-memory channels, one per column. Each   |
// |           channel has a valid/ready request port, a single-port SRAM      |
// |           model, a 2-entry in-order response queue, credit-based          |
// |           backpressure, out-of-range / reserved-op error responses and a  |
// |           staged active-low reset fan-out.                                |
// | Option  : BSG_BLOCK_MEM_CHANNEL_AMO_EN -- when defined, op 10 performs an  |
// |           atomic add (read, then write old+operand one cycle later).     |
// |           When undefined, op 10 returns an error like op 11.             |
// | Ports   : clk_i, reset_n_i (async, active low)                            |
// |           reset_n_o[C]             staged per-channel reset out          |
// |           v_i/op_i/addr_i/data_i/mask_i/ready_o  request side           |
// |           v_o/data_o/err_o/yumi_i                response side          |
// |           Channel c occupies slice index c of every packed port.         |
// | Revision: 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bsg_manycore_block_mem_channel_array #(
  parameter int num_channels_p = 4,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 16,
  parameter int els_p          = 1024,
  parameter int reset_depth_p  = 2
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  output logic [num_channels_p-1:0]                  reset_n_o,
  input  logic [num_channels_p-1:0]                  v_i,
  input  logic [2*num_channels_p-1:0]                op_i,
  input  logic [addr_width_p*num_channels_p-1:0]     addr_i,
  input  logic [data_width_p*num_channels_p-1:0]     data_i,
  input  logic [(data_width_p/8)*num_channels_p-1:0] mask_i,
  output logic [num_channels_p-1:0]                  ready_o,
  output logic [num_channels_p-1:0]                  v_o,
  output logic [data_width_p*num_channels_p-1:0]     data_o,
  output logic [num_channels_p-1:0]                  err_o,
  input  logic [num_channels_p-1:0]                  yumi_i
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1;
  // One extra bit so els_p == 2**addr_width_p is still representable.
  localparam logic [addr_width_p:0] els_lim_lp = (addr_width_p + 1)'(els_p);

  localparam logic [1:0] op_load_lp   = 2'b00;
  localparam logic [1:0] op_store_lp  = 2'b01;
  localparam logic [1:0] op_amoadd_lp = 2'b10;
  localparam logic [1:0] op_rsvd_lp   = 2'b11;

`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    AMO_WR = 1'b1
  } state_e;
`endif

  for (genvar c = 0; c < num_channels_p; c++) begin : g_chan

    logic [1:0]               op;
    logic [addr_width_p-1:0]  addr;
    logic [data_width_p-1:0]  wdata;
    logic [mask_width_lp-1:0] mask;

    assign op    = op_i[2*c +: 2];
    assign addr  = addr_i[addr_width_p*c +: addr_width_p];
    assign wdata = data_i[data_width_p*c +: data_width_p];
    assign mask  = mask_i[mask_width_lp*c +: mask_width_lp];

    // ---------------- staged reset fan-out ----------------
    logic [reset_depth_p-1:0] rst_stage_q, rst_stage_d;

    always_comb begin
      rst_stage_d    = rst_stage_q;
      rst_stage_d[0] = 1'b1;
      for (int i = 1; i < reset_depth_p; i++) begin
        rst_stage_d[i] = rst_stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_stage_q <= '0;
      else            rst_stage_q <= rst_stage_d;
    end

    assign reset_n_o[c] = rst_stage_q[reset_depth_p-1];

    // Holds ready_o low until the first clock edge after reset release.
    logic live_q, live_d;
    assign live_d = 1'b1;

    // ---------------- SRAM model ----------------
    logic [data_width_p-1:0] mem [els_p];
    logic [lg_els_lp-1:0]    idx;
    logic [data_width_p-1:0] rd_word;
    logic [data_width_p-1:0] merged;
    logic                    mem_we;
    logic [lg_els_lp-1:0]    mem_widx;
    logic [data_width_p-1:0] mem_wdata;

    assign idx     = addr[lg_els_lp-1:0];
    assign rd_word = mem[idx];

    always_comb begin
      merged = rd_word;
      for (int b = 0; b < mask_width_lp; b++) begin
        if (mask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end

    always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    // ---------------- request decode / credits ----------------
    logic       addr_err, op_bad, req_err;
    logic       amo_busy;
    logic [1:0] cnt;
    logic       accept;
    logic [1:0] q_cnt_q, q_cnt_d;

    assign addr_err = ({1'b0, addr} >= els_lim_lp);
`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
    assign op_bad   = (op == op_rsvd_lp);
`else
    assign op_bad   = (op == op_rsvd_lp) | (op == op_amoadd_lp);
`endif
    assign req_err  = addr_err | op_bad;

    // An amo waiting for its write phase holds a credit for its response.
    assign cnt          = q_cnt_q + {1'b0, amo_busy};
    assign ready_o[c]   = live_q & ~amo_busy & (cnt < 2'd2);
    assign accept       = v_i[c] & ready_o[c];

    // ---------------- FSM / request execution ----------------
    logic                    enq;
    logic [data_width_p-1:0] enq_data;
    logic                    enq_err;

`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
    state_e                  state_q, state_d;
    logic [lg_els_lp-1:0]    amo_idx_q, amo_idx_d;
    logic [data_width_p-1:0] amo_old_q, amo_old_d;
    logic [data_width_p-1:0] amo_opnd_q, amo_opnd_d;

    assign amo_busy = (state_q == AMO_WR);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q    <= IDLE;
        amo_idx_q  <= '0;
        amo_old_q  <= '0;
        amo_opnd_q <= '0;
      end else begin
        state_q    <= state_d;
        amo_idx_q  <= amo_idx_d;
        amo_old_q  <= amo_old_d;
        amo_opnd_q <= amo_opnd_d;
      end
    end
`else
    assign amo_busy = 1'b0;
`endif

    always_comb begin
      enq       = 1'b0;
      enq_data  = '0;
      enq_err   = 1'b0;
      mem_we    = 1'b0;
      mem_widx  = idx;
      mem_wdata = merged;
`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
      state_d    = state_q;
      amo_idx_d  = amo_idx_q;
      amo_old_d  = amo_old_q;
      amo_opnd_d = amo_opnd_q;
      if (state_q == AMO_WR) begin
        // Write phase: sum wraps, response carries the pre-add value.
        mem_we    = 1'b1;
        mem_widx  = amo_idx_q;
        mem_wdata = amo_old_q + amo_opnd_q;
        enq       = 1'b1;
        enq_data  = amo_old_q;
        state_d   = IDLE;
      end else
`endif
      if (accept) begin
        if (req_err) begin
          enq     = 1'b1;
          enq_err = 1'b1;
        end else begin
          case (op)
            op_load_lp: begin
              enq      = 1'b1;
              enq_data = rd_word;
            end
            op_store_lp: begin
              enq    = 1'b1;
              mem_we = 1'b1;
            end
`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
            op_amoadd_lp: begin
              state_d    = AMO_WR;
              amo_idx_d  = idx;
              amo_old_d  = rd_word;
              amo_opnd_d = wdata;
            end
`endif
            default: ;
          endcase
        end
      end
    end

    // ---------------- 2-entry response queue ----------------
    logic [data_width_p-1:0] q_data_q [2];
    logic [data_width_p-1:0] q_data_d [2];
    logic [1:0]              q_err_q, q_err_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    deq;

    assign v_o[c] = (q_cnt_q != 2'd0);
    assign deq    = yumi_i[c] & v_o[c];

    always_comb begin
      q_data_d = q_data_q;
      q_err_d  = q_err_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      q_cnt_d  = q_cnt_q;
      if (enq) begin
        q_data_d[wr_ptr_q] = enq_data;
        q_err_d[wr_ptr_q]  = enq_err;
        wr_ptr_d           = ~wr_ptr_q;
      end
      if (deq) rd_ptr_d = ~rd_ptr_q;
      case ({enq, deq})
        2'b10:   q_cnt_d = q_cnt_q + 2'd1;
        2'b01:   q_cnt_d = q_cnt_q - 2'd1;
        default: ;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        live_q      <= 1'b0;
        q_data_q[0] <= '0;
        q_data_q[1] <= '0;
        q_err_q     <= '0;
        rd_ptr_q    <= 1'b0;
        wr_ptr_q    <= 1'b0;
        q_cnt_q     <= '0;
      end else begin
        live_q      <= live_d;
        q_data_q[0] <= q_data_d[0];
        q_data_q[1] <= q_data_d[1];
        q_err_q     <= q_err_d;
        rd_ptr_q    <= rd_ptr_d;
        wr_ptr_q    <= wr_ptr_d;
        q_cnt_q     <= q_cnt_d;
      end
    end

    // Head of queue is presented only while valid; otherwise outputs read 0.
    assign data_o[data_width_p*c +: data_width_p] = v_o[c] ? q_data_q[rd_ptr_q] : '0;
    assign err_o[c]                               = v_o[c] & q_err_q[rd_ptr_q];

    a_yumi_needs_valid: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) yumi_i[c] |-> v_o[c]);

  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_block_mem_channel_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bsg_manycore_block_mem_channel_array                          |
// | Purpose : Self-checking bench: directed scenarios plus randomized traffic |
// |           against a transaction-level model of every channel.            |
// | Revision: 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bsg_manycore_block_mem_channel_array;

  localparam int C  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MW = 4;
  localparam int ELS = 1024;

`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
  localparam bit amo_en_lp = 1'b1;
`else
  localparam bit amo_en_lp = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic [C-1:0]      reset_n_o;
  logic [C-1:0]      v_i;
  logic [2*C-1:0]    op_i;
  logic [AW*C-1:0]   addr_i;
  logic [DW*C-1:0]   data_i;
  logic [MW*C-1:0]   mask_i;
  logic [C-1:0]      ready_o;
  logic [C-1:0]      v_o;
  logic [DW*C-1:0]   data_o;
  logic [C-1:0]      err_o;
  logic [C-1:0]      yumi_i;

  always #5 clk = ~clk;

  bsg_manycore_block_mem_channel_array #(
    .num_channels_p(C), .data_width_p(DW), .addr_width_p(AW),
    .els_p(ELS), .reset_depth_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .reset_n_o(reset_n_o),
    .v_i(v_i), .op_i(op_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .err_o(err_o), .yumi_i(yumi_i)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    bit          err;
    int          due;    // first sample index at which it may be at the head
    bit          known;  // data is checkable (SRAM word was initialised)
  } resp_t;

  resp_t       mq [C][$];
  logic [31:0] mmem [C][ELS];
  bit          mk [C][ELS];
  int          amo_wr_t [C];
  int          t;

  int n_pass  = 0;
  int n_total = 0;

  // per-channel driven request
  bit   [C-1:0] d_v, d_yumi;
  logic [1:0]   d_op   [C];
  logic [15:0]  d_addr [C];
  logic [31:0]  d_data [C];
  logic [3:0]   d_mask [C];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
  endtask

  function automatic bit exp_v(input int c);
    return (mq[c].size() > 0) && (mq[c][0].due <= t);
  endfunction

  function automatic bit exp_ready(input int c);
    return (mq[c].size() < 2) && (amo_wr_t[c] != t);
  endfunction

  task automatic model_edge(input int c);
    bit    acc;
    resp_t r;
    int    a;
    acc = v_i[c] && exp_ready(c);
    if (yumi_i[c]) void'(mq[c].pop_front());
    if (acc) begin
      a       = int'(d_addr[c]);
      r.data  = 32'h0;
      r.err   = 1'b0;
      r.known = 1'b1;
      r.due   = t + 1;
      if (a >= ELS || d_op[c] == 2'b11 || (d_op[c] == 2'b10 && !amo_en_lp)) begin
        r.err = 1'b1;
      end else if (d_op[c] == 2'b00) begin
        r.data  = mmem[c][a];
        r.known = mk[c][a];
      end else if (d_op[c] == 2'b01) begin
        for (int b = 0; b < 4; b++)
          if (d_mask[c][b]) mmem[c][a][8*b +: 8] = d_data[c][8*b +: 8];
        if (d_mask[c] == 4'hF) mk[c][a] = 1'b1;
      end else begin
        r.data      = mmem[c][a];
        r.known     = mk[c][a];
        mmem[c][a]  = mmem[c][a] + d_data[c];
        r.due       = t + 2;
        amo_wr_t[c] = t + 1;
      end
      mq[c].push_back(r);
    end
  endtask

  task automatic check_chan(input int c);
    check($sformatf("ready_ch%0d", c), {31'b0, ready_o[c]}, {31'b0, exp_ready(c)});
    check($sformatf("v_ch%0d", c), {31'b0, v_o[c]}, {31'b0, exp_v(c)});
    if (exp_v(c)) begin
      check($sformatf("err_ch%0d", c), {31'b0, err_o[c]}, {31'b0, mq[c][0].err});
      if (mq[c][0].known)
        check($sformatf("data_ch%0d", c), data_o[DW*c +: DW], mq[c][0].data);
    end
  endtask

  // One clock: drive, advance the model across the edge, sample and check.
  task automatic cycle();
    for (int c = 0; c < C; c++) begin
      v_i[c]              = d_v[c];
      op_i[2*c +: 2]      = d_op[c];
      addr_i[AW*c +: AW]  = d_addr[c];
      data_i[DW*c +: DW]  = d_data[c];
      mask_i[MW*c +: MW]  = d_mask[c];
      yumi_i[c]           = d_yumi[c] & exp_v(c);
    end
    for (int c = 0; c < C; c++) model_edge(c);
    @(posedge clk);
    #1;
    t++;
    for (int c = 0; c < C; c++) check_chan(c);
  endtask

  task automatic req(input int c, input logic [1:0] op, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    d_v[c]    = 1'b1;
    d_op[c]   = op;
    d_addr[c] = a;
    d_data[c] = d;
    d_mask[c] = m;
  endtask

  task automatic clr();
    d_v = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0;
    v_i = '0; op_i = '0; addr_i = '0; data_i = '0; mask_i = '0; yumi_i = '0;
    d_v = '0; d_yumi = '0;
    for (int c = 0; c < C; c++) begin
      d_op[c] = '0; d_addr[c] = '0; d_data[c] = '0; d_mask[c] = '0;
      amo_wr_t[c] = -1;
      for (int a = 0; a < ELS; a++) begin
        mmem[c][a] = '0;
        mk[c][a]   = 1'b0;
      end
    end
    t = 0;

    // ---- reset ----
    repeat (5) @(posedge clk);
    #1;
    check("rst_v", {28'b0, v_o}, 32'h0);
    check("rst_ready", {28'b0, ready_o}, 32'h0);
    check("rst_err", {28'b0, err_o}, 32'h0);
    check("rst_rsto", {28'b0, reset_n_o}, 32'h0);
    for (int c = 0; c < C; c++) check($sformatf("rst_data_ch%0d", c), data_o[DW*c +: DW], 32'h0);
    reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    check("rel1_ready", {28'b0, ready_o}, 32'hF);
    check("rel1_rsto", {28'b0, reset_n_o}, 32'h0);
    @(posedge clk);
    #1;
    check("rel2_rsto", {28'b0, reset_n_o}, 32'hF);
    t = 0;

    // ---- store then load ----
    d_yumi = '1;
    req(0, 2'b01, 16'd5, 32'hDEADBEEF, 4'hF); cycle();
    req(0, 2'b00, 16'd5, 32'h0, 4'h0);        cycle();
    check("t2_load_v", {31'b0, v_o[0]}, 32'h1);
    check("t2_load_data", data_o[31:0], 32'hDEADBEEF);
    check("t2_other_v", {29'b0, v_o[3:1]}, 32'h0);
    clr(); cycle();

    // ---- masked store ----
    req(0, 2'b01, 16'd7, 32'hFFFFFFFF, 4'hF); cycle();
    req(0, 2'b01, 16'd7, 32'h11223344, 4'h5); cycle();
    req(0, 2'b00, 16'd7, 32'h0, 4'h0);        cycle();
    check("t3_masked", data_o[31:0], 32'hFF22FF44);
    clr(); cycle();

    // ---- out-of-range ----
    req(0, 2'b01, 16'd0, 32'hA5A5A5A5, 4'hF);    cycle();
    req(0, 2'b01, 16'd1024, 32'h12345678, 4'hF); cycle();
    check("t4_err", {31'b0, err_o[0]}, 32'h1);
    check("t4_err_data", data_o[31:0], 32'h0);
    req(0, 2'b00, 16'd0, 32'h0, 4'h0); cycle();
    check("t4_word0", data_o[31:0], 32'hA5A5A5A5);
    clr(); cycle();

    // ---- backpressure ----
    d_yumi = '0;
    req(0, 2'b00, 16'd5, 32'h0, 4'h0); cycle();
    req(0, 2'b00, 16'd7, 32'h0, 4'h0); cycle();
    check("t5_full", {31'b0, ready_o[0]}, 32'h0);
    req(0, 2'b00, 16'd0, 32'h0, 4'h0); cycle();
    check("t5_head", data_o[31:0], 32'hDEADBEEF);
    d_yumi[0] = 1'b1; cycle();
    check("t5_reopen", {31'b0, ready_o[0]}, 32'h1);
    check("t5_second", data_o[31:0], 32'hFF22FF44);
    d_yumi[0] = 1'b0; cycle();
    clr(); d_yumi = '1;
    cycle();
    check("t5_third", data_o[31:0], 32'hA5A5A5A5);
    repeat (3) cycle();

    // ---- amoadd ----
    req(0, 2'b01, 16'd9, 32'hFFFFFFFF, 4'hF); cycle();
    req(0, 2'b10, 16'd9, 32'h00000002, 4'hF); cycle();
`ifdef BSG_BLOCK_MEM_CHANNEL_AMO_EN
    check("t6_busy", {31'b0, ready_o[0]}, 32'h0);
    check("t6_nov", {31'b0, v_o[0]}, 32'h0);
    clr(); cycle();
    check("t6_old_v", {31'b0, v_o[0]}, 32'h1);
    check("t6_old", data_o[31:0], 32'hFFFFFFFF);
    req(0, 2'b00, 16'd9, 32'h0, 4'h0); cycle();
    check("t6_sum", data_o[31:0], 32'h00000001);
`else
    check("t6_err", {31'b0, err_o[0]}, 32'h1);
    check("t6_err_data", data_o[31:0], 32'h0);
    req(0, 2'b00, 16'd9, 32'h0, 4'h0); cycle();
    check("t6_unchanged", data_o[31:0], 32'hFFFFFFFF);
`endif
    clr(); cycle(); cycle();

    // ---- randomized traffic on all channels ----
    for (int a = 0; a < 16; a++) begin
      for (int c = 0; c < C; c++) req(c, 2'b01, 16'(a), $urandom, 4'hF);
      cycle();
    end
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < C; c++) begin
        d_v[c]    = ($urandom_range(0, 9) < 7);
        d_op[c]   = 2'($urandom_range(0, 3));
        d_addr[c] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                                : 16'($urandom_range(0, 15));
        d_data[c] = $urandom;
        d_mask[c] = 4'($urandom);
        d_yumi[c] = ($urandom_range(0, 9) < 6);
      end
      cycle();
    end
    clr(); d_yumi = '1;
    repeat (6) cycle();
    check("drain_v", {28'b0, v_o}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
